// File: rtl/mem_arbiter_pkg.sv
// Shared wires for the instruction/data memory arbiter.
// Request bundle and arbiter state encoding.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IMEM,
    DMEM
  } arb_state_type;

  typedef struct packed {
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_in_type;

endpackage

// File: rtl/arbiter_slot.sv
// One-deep pending request register for a single cpu port.
// Accepts a new request when empty or in the cycle it completes.
module arbiter_slot
  import mem_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  mem_in_type req,
  input  logic       done,
  output mem_in_type slot
);

  mem_in_type q;
  mem_in_type d;

  always_comb begin
    d = q;
    if (done)
      d = '0;
    if (req.valid && (!q.valid || done))
      d = req;
  end

  always_ff @(posedge clock) begin
    if (reset)
      q <= '0;
    else
      q <= d;
  end

  assign slot = q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto one shared memory.
// One outstanding request at a time; round-robin or data-first ties.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit round_robin = 1'b1
) (
  input  logic        reset,
  input  logic        clock,
  input  logic        imemory_valid,
  input  logic        imemory_instr,
  input  logic [31:0] imemory_addr,
  input  logic [31:0] imemory_wdata,
  input  logic [3:0]  imemory_wstrb,
  output logic [31:0] imemory_rdata,
  output logic        imemory_ready,
  input  logic        dmemory_valid,
  input  logic        dmemory_instr,
  input  logic [31:0] dmemory_addr,
  input  logic [31:0] dmemory_wdata,
  input  logic [3:0]  dmemory_wstrb,
  output logic [31:0] dmemory_rdata,
  output logic        dmemory_ready,
  output logic        memory_valid,
  output logic        memory_instr,
  output logic [31:0] memory_addr,
  output logic [31:0] memory_wdata,
  output logic [3:0]  memory_wstrb,
  input  logic [31:0] memory_rdata,
  input  logic        memory_ready
);

  arb_state_type state, state_n;
  logic          last_d, last_d_n;
  logic          grant_d;
  mem_in_type    ireq, dreq;
  mem_in_type    islot, dslot;
  mem_in_type    issue;

  assign ireq = '{valid: imemory_valid, instr: imemory_instr,
                  addr: imemory_addr, wdata: imemory_wdata,
                  wstrb: imemory_wstrb};
  assign dreq = '{valid: dmemory_valid, instr: dmemory_instr,
                  addr: dmemory_addr, wdata: dmemory_wdata,
                  wstrb: dmemory_wstrb};

  arbiter_slot u_islot (
    .clock (clock),
    .reset (reset),
    .req   (ireq),
    .done  (imemory_ready),
    .slot  (islot)
  );

  arbiter_slot u_dslot (
    .clock (clock),
    .reset (reset),
    .req   (dreq),
    .done  (dmemory_ready),
    .slot  (dslot)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      state  <= state_n;
      last_d <= last_d_n;
    end
  end

  // Data wins a tie unless round-robin says it was served last.
  assign grant_d = dslot.valid &&
    (!islot.valid || !round_robin || !last_d);

  always_comb begin
    state_n       = state;
    last_d_n      = last_d;
    issue         = '0;
    imemory_ready = 1'b0;
    imemory_rdata = '0;
    dmemory_ready = 1'b0;
    dmemory_rdata = '0;
    unique case (state)
      IDLE: begin
        if (islot.valid || dslot.valid) begin
          issue    = grant_d ? dslot : islot;
          state_n  = grant_d ? DMEM : IMEM;
          last_d_n = grant_d;
        end
      end
      IMEM: begin
        if (memory_ready) begin
          imemory_ready = 1'b1;
          imemory_rdata = memory_rdata;
          state_n       = IDLE;
        end
      end
      DMEM: begin
        if (memory_ready) begin
          dmemory_ready = 1'b1;
          dmemory_rdata = memory_rdata;
          state_n       = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // A reset cycle abandons whatever is in flight and shows nothing.
    if (reset) begin
      issue         = '0;
      imemory_ready = 1'b0;
      imemory_rdata = '0;
      dmemory_ready = 1'b0;
      dmemory_rdata = '0;
    end
  end

  assign memory_valid = issue.valid;
  assign memory_instr = issue.instr;
  assign memory_addr  = issue.addr;
  assign memory_wdata = issue.wdata;
  assign memory_wstrb = issue.wstrb;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one round-robin and one
// data-first instance share stimulus.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        iv, ii, dv, di, mready;
  logic [31:0] ia, iw, da, dw, mrdata;
  logic [3:0]  is, ds;

  logic [31:0] r_irdata, r_drdata, r_maddr, r_mwdata;
  logic        r_iready, r_dready, r_mvalid, r_minstr;
  logic [3:0]  r_mwstrb;
  logic [31:0] f_irdata, f_drdata, f_maddr, f_mwdata;
  logic        f_iready, f_dready, f_mvalid, f_minstr;
  logic [3:0]  f_mwstrb;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  mem_arbiter #(.round_robin(1'b1)) u_rr (
    .reset(reset), .clock(clock),
    .imemory_valid(iv), .imemory_instr(ii), .imemory_addr(ia),
    .imemory_wdata(iw), .imemory_wstrb(is),
    .imemory_rdata(r_irdata), .imemory_ready(r_iready),
    .dmemory_valid(dv), .dmemory_instr(di), .dmemory_addr(da),
    .dmemory_wdata(dw), .dmemory_wstrb(ds),
    .dmemory_rdata(r_drdata), .dmemory_ready(r_dready),
    .memory_valid(r_mvalid), .memory_instr(r_minstr),
    .memory_addr(r_maddr), .memory_wdata(r_mwdata),
    .memory_wstrb(r_mwstrb),
    .memory_rdata(mrdata), .memory_ready(mready)
  );

  mem_arbiter #(.round_robin(1'b0)) u_fix (
    .reset(reset), .clock(clock),
    .imemory_valid(iv), .imemory_instr(ii), .imemory_addr(ia),
    .imemory_wdata(iw), .imemory_wstrb(is),
    .imemory_rdata(f_irdata), .imemory_ready(f_iready),
    .dmemory_valid(dv), .dmemory_instr(di), .dmemory_addr(da),
    .dmemory_wdata(dw), .dmemory_wstrb(ds),
    .dmemory_rdata(f_drdata), .dmemory_ready(f_dready),
    .memory_valid(f_mvalid), .memory_instr(f_minstr),
    .memory_addr(f_maddr), .memory_wdata(f_mwdata),
    .memory_wstrb(f_mwstrb),
    .memory_rdata(mrdata), .memory_ready(mready)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got === exp)
      passed++;
    else
      $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance to just after the next edge; pulses drop back to 0.
  task automatic step();
    @(posedge clock);
    #1;
    iv = 0; dv = 0; mready = 0; mrdata = '0;
    ii = 0; ia = '0; iw = '0; is = '0;
    di = 0; da = '0; dw = '0; ds = '0;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  initial begin
    reset = 1;
    iv = 0; dv = 0; mready = 0; mrdata = '0;
    ii = 0; ia = '0; iw = '0; is = '0;
    di = 0; da = '0; dw = '0; ds = '0;
    step(); reset = 1;
    mid();
    chk("rst_mvalid", {31'd0, r_mvalid}, 0);
    chk("rst_iready", {31'd0, r_iready}, 0);
    chk("rst_dready", {31'd0, r_dready}, 0);
    chk("rst_maddr", r_maddr, 0);
    step(); reset = 0;

    // single read on the instruction port
    iv = 1; ii = 1; ia = 32'h100;
    mid(); chk("rd_same_cycle", {31'd0, r_mvalid}, 0);
    step();
    mid();
    chk("rd_mvalid", {31'd0, r_mvalid}, 1);
    chk("rd_maddr", r_maddr, 32'h100);
    chk("rd_minstr", {31'd0, r_minstr}, 1);
    step();
    mid(); chk("rd_wait_mvalid", {31'd0, r_mvalid}, 0);
    step(); mready = 1; mrdata = 32'hDEADBEEF;
    mid();
    chk("rd_iready", {31'd0, r_iready}, 1);
    chk("rd_irdata", r_irdata, 32'hDEADBEEF);
    chk("rd_dready", {31'd0, r_dready}, 0);
    chk("rd_drdata", r_drdata, 0);
    step();
    mid(); chk("rd_iready_pulse", {31'd0, r_iready}, 0);

    // ties: rr instance alternates, fixed instance favours data
    reset = 1; step(); reset = 0;
    iv = 1; ia = 32'h0; dv = 1; da = 32'h2000;
    step();
    mid();
    chk("tie1_rr_addr", r_maddr, 32'h2000);
    chk("tie1_fix_addr", f_maddr, 32'h2000);
    step(); mready = 1; mrdata = 32'hA; dv = 1; da = 32'h2040;
    mid();
    chk("tie1_rr_dready", {31'd0, r_dready}, 1);
    chk("tie1_rr_drdata", r_drdata, 32'hA);
    chk("tie1_rr_iready", {31'd0, r_iready}, 0);
    step();
    mid();
    chk("tie2_rr_addr", r_maddr, 32'h0);
    chk("tie2_fix_addr", f_maddr, 32'h2040);
    step(); mready = 1; mrdata = 32'hB; dv = 1; da = 32'h2080;
    mid();
    chk("tie2_rr_iready", {31'd0, r_iready}, 1);
    chk("tie2_fix_dready", {31'd0, f_dready}, 1);
    chk("tie2_fix_irdata", f_irdata, 0);
    step();
    mid();
    chk("rr_next_addr", r_maddr, 32'h2040);
    chk("tie3_fix_addr", f_maddr, 32'h2080);
    step(); mready = 1; mrdata = 32'hC;
    mid();
    chk("rr_dready", {31'd0, r_dready}, 1);
    chk("fix_dready", {31'd0, f_dready}, 1);
    step();
    mid();
    chk("rr_dup_ignored", {31'd0, r_mvalid}, 0);
    chk("fix_last_addr", f_maddr, 32'h0);
    chk("fix_last_valid", {31'd0, f_mvalid}, 1);
    step(); mready = 1; mrdata = 32'hD;
    mid(); chk("fix_iready", {31'd0, f_iready}, 1);
    step();

    // write on the data port
    dv = 1; da = 32'h3004; dw = 32'h12345678; ds = 4'hF;
    step();
    mid();
    chk("wr_mvalid", {31'd0, r_mvalid}, 1);
    chk("wr_maddr", r_maddr, 32'h3004);
    chk("wr_mwdata", r_mwdata, 32'h12345678);
    chk("wr_mwstrb", {28'd0, r_mwstrb}, 32'hF);
    chk("wr_minstr", {31'd0, r_minstr}, 0);
    step(); mready = 1;
    mid();
    chk("wr_dready", {31'd0, r_dready}, 1);
    chk("wr_iready", {31'd0, r_iready}, 0);
    step();

    // reset while the instruction request is in flight
    iv = 1; ia = 32'h500;
    step();
    mid(); chk("rm_issue", r_maddr, 32'h500);
    step(); reset = 1; dv = 1; da = 32'h600;
    mid();
    chk("rm_rst_mvalid", {31'd0, r_mvalid}, 0);
    chk("rm_rst_iready", {31'd0, r_iready}, 0);
    step(); reset = 0;
    mid(); chk("rm_drop_mvalid", {31'd0, r_mvalid}, 0);
    step(); mready = 1; mrdata = 32'hBAD;
    mid();
    chk("rm_stray_iready", {31'd0, r_iready}, 0);
    chk("rm_stray_irdata", r_irdata, 0);
    chk("rm_stray_mvalid", {31'd0, r_mvalid}, 0);
    step();

    // ready and new data valid in the same cycle; duplicate ignored
    dv = 1; da = 32'h20;
    step(); dv = 1; da = 32'h99;
    mid(); chk("bb_first_addr", r_maddr, 32'h20);
    step(); mready = 1; mrdata = 32'h55; dv = 1; da = 32'h40;
    mid(); chk("bb_dready", {31'd0, r_dready}, 1);
    step();
    mid();
    chk("bb_second_valid", {31'd0, r_mvalid}, 1);
    chk("bb_second_addr", r_maddr, 32'h40);
    step(); mready = 1;
    mid(); chk("bb_second_dready", {31'd0, r_dready}, 1);
    step();
    mid(); chk("bb_dup_ignored", {31'd0, r_mvalid}, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: round_robin, default 1, 1 = alternate grant on tie, 0 = data port always wins tie.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 clock  input  1  single clock, rising edge.
REQ-004 imemory_valid/instr/addr/wdata/wstrb  input  1/1/32/32/4  instruction-port request from cpu.
REQ-005 imemory_rdata/ready  output  32/1  instruction-port response to cpu.
REQ-006 dmemory_valid/instr/addr/wdata/wstrb  input  1/1/32/32/4  data-port request from cpu.
REQ-007 dmemory_rdata/ready  output  32/1  data-port response to cpu.
REQ-008 memory_valid/instr/addr/wdata/wstrb  output  1/1/32/32/4  merged request to shared memory.
REQ-009 memory_rdata/ready  input  32/1  shared-memory response.

Function
REQ-010 Request protocol SHALL be: valid is a one-cycle pulse with attributes valid in that cycle; ready is a one-cycle pulse completing the request.
REQ-011 Each port SHALL have one pending slot capturing instr/addr/wdata/wstrb on valid; at most one outstanding request per port.
REQ-012 A valid on a port whose slot is pending or active SHALL be ignored, except in the cycle that port's ready is returned, when it SHALL be captured.
REQ-013 FSM states SHALL be IDLE, IMEM, DMEM.
REQ-014 IDLE: if any slot pending, select a winner, drive memory_valid high one cycle with that slot's attributes, go to IMEM/DMEM; else stay.
REQ-015 Requests SHALL be issued no earlier than the cycle after capture (one cycle added latency minimum).
REQ-016 Tie (both pending): round_robin=1 grants the port not served last; round_robin=0 grants data port.
REQ-017 IMEM/DMEM: memory_valid SHALL be low; on memory_ready, route memory_rdata and a one-cycle ready to the granted port in the same cycle, clear its slot, return to IDLE.
REQ-018 Non-granted port ready SHALL be 0; its rdata SHALL be 0.
REQ-019 memory_ready in IDLE SHALL be ignored.
REQ-020 Back-to-back: a still-pending slot SHALL be issued the cycle after the ready (IDLE one cycle).
REQ-021 memory_wdata/wstrb SHALL pass unchanged; write requests (wstrb!=0) SHALL arbitrate identically to reads.

Reset
REQ-022 On reset: state IDLE, both slots empty, last-served = instruction port, all outputs 0.
REQ-023 Reset mid-transaction SHALL abandon the active request with no ready delivered to the cpu; a later stray memory_ready SHALL be ignored.
REQ-024 Requests presented in a reset cycle SHALL be dropped.

Structure
REQ-025 Arbiter state enum (arb_state_type) SHALL live in the shared wires package; slot contents SHALL reuse mem_in_type.
REQ-026 One sub-module, arbiter_slot, SHALL implement a per-port capture register (instantiated twice).
REQ-027 Implementation SHALL be 120-400 lines, comb/seq split consistent with stage modules.

Verification
REQ-028 Single read: imemory_valid at cycle 0, addr 0x100; memory_valid at cycle 1 addr 0x100; memory_ready cycle 3 rdata 0xDEADBEEF -> imemory_ready=1, imemory_rdata=0xDEADBEEF in cycle 3.
REQ-029 Tie after reset, round_robin=1: both valid cycle 0 (i 0x0, d 0x2000) -> data issued cycle 1, instruction issued cycle after data ready; next tie grants instruction.
REQ-030 round_robin=0: three consecutive ties -> data port wins all three.
REQ-031 Write: dmemory_valid addr 0x3004 wdata 0x12345678 wstrb 0xF -> memory_* carry identical values; dmemory_ready on completion, imemory_ready stays 0.
REQ-032 Reset mid-transaction: reset in IMEM, memory_ready two cycles later -> no imemory_ready, state IDLE, memory_valid 0.
REQ-033 Same-cycle ready and new dmemory_valid (addr 0x40) -> new request captured and issued the following cycle; duplicate valid while pending ignored.
